alu_arbiter: RTL and testbench

//  Shares one W-bit combinational ALU (add/sub/and/xor, built from the team's 32-bit cells) between two requesters.

---
 rtl/alu_pkg.sv | 13 +
 rtl/alu_core.sv | 34 +++
 rtl/alu_arbiter.sv | 104 ++++++++++
 tb/tb_alu_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: op encodings, FSM state encoding and condition-code bit indices for alu_arbiter
package alu_pkg;
   localparam logic [1:0] ALU_ADD = 2'd0;
   localparam logic [1:0] ALU_SUB = 2'd1;
   localparam logic [1:0] ALU_AND = 2'd2;
   localparam logic [1:0] ALU_XOR = 2'd3;
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;
   localparam int CC_ZF = 2;
   localparam int CC_SF = 1;
   localparam int CC_OF = 0;
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational add/sub/and/xor; ZF/SF/OF outputs exist only with ALU_CC_EN
module alu_core
   import alu_pkg::*;
#(
   parameter int W   = 32,
   parameter int OPW = 2
) (
   input  logic [OPW-1:0] op,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic [W-1:0]   result
`ifdef ALU_CC_EN
   ,
   output logic           zf,
   output logic           sf,
   output logic           of
`endif
);
   // Subtract is b-a to match the Y86 subq operand order
   always_comb begin
      result = op == ALU_ADD ? a + b :
               op == ALU_SUB ? b - a :
               op == ALU_AND ? a & b : a ^ b;
   end
`ifdef ALU_CC_EN
   // Signed overflow only exists for add/sub; logic ops never overflow
   always_comb begin
      zf = result == '0;
      sf = result[W-1];
      of = op == ALU_ADD ? (a[W-1] == b[W-1]) && (result[W-1] != a[W-1]) :
           op == ALU_SUB ? (a[W-1] != b[W-1]) && (result[W-1] != b[W-1]) : 1'b0;
   end
`endif
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one ALU between two requesters; rsp_cc exists only with ALU_CC_EN
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int W   = 32,
   parameter int OPW = 2
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           req0_valid,
   output logic           req0_ready,
   input  logic [OPW-1:0] req0_op,
   input  logic [W-1:0]   req0_a,
   input  logic [W-1:0]   req0_b,
   input  logic           req1_valid,
   output logic           req1_ready,
   input  logic [OPW-1:0] req1_op,
   input  logic [W-1:0]   req1_a,
   input  logic [W-1:0]   req1_b,
   output logic           rsp0_valid,
   input  logic           rsp0_ready,
   output logic           rsp1_valid,
   input  logic           rsp1_ready,
   output logic [W-1:0]   rsp_result
`ifdef ALU_CC_EN
   ,
   output logic [2:0]     rsp_cc
`endif
);
   logic [1:0]     state;
   logic           ptr;
   logic           owner;
   logic           gnt1;
   logic           take;
   logic [OPW-1:0] op_q;
   logic [W-1:0]   a_q;
   logic [W-1:0]   b_q;
   logic [W-1:0]   res;
`ifdef ALU_CC_EN
   logic           zf;
   logic           sf;
   logic           of;
`endif

   alu_core #(.W(W), .OPW(OPW)) u_core (
      .op(op_q),
      .a(a_q),
      .b(b_q),
      .result(res)
`ifdef ALU_CC_EN
      ,
      .zf(zf),
      .sf(sf),
      .of(of)
`endif
   );

   // Grant: requester 1 wins when alone or when the pointer favours it; readies held low during reset
   always_comb begin
      gnt1       = req1_valid && (!req0_valid || ptr);
      req0_ready = !rst && state == ST_IDLE && req0_valid && !gnt1;
      req1_ready = !rst && state == ST_IDLE && gnt1;
      rsp0_valid = state == ST_RESP && !owner;
      rsp1_valid = state == ST_RESP && owner;
      take       = owner ? rsp1_ready : rsp0_ready;
   end

   // FSM, round-robin pointer, operand latches and registered result
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         ptr        <= 1'b0;
         owner      <= 1'b0;
         rsp_result <= '0;
      end else if (state == ST_IDLE) begin
         if (req0_ready || req1_ready) begin
            owner <= gnt1;
            ptr   <= !gnt1;
            op_q  <= gnt1 ? req1_op : req0_op;
            a_q   <= gnt1 ? req1_a : req0_a;
            b_q   <= gnt1 ? req1_b : req0_b;
            state <= ST_EXEC;
         end
      end else if (state == ST_EXEC) begin
         rsp_result <= res;
         state      <= ST_RESP;
      end else if (state != ST_RESP || take) begin
         state <= ST_IDLE;
      end
   end

`ifdef ALU_CC_EN
   // Condition codes captured in the same cycle as the result
   always_ff @(posedge clk) begin
      if (rst)
         rsp_cc <= '0;
      else if (state == ST_EXEC) begin
         rsp_cc[CC_ZF] <= zf;
         rsp_cc[CC_SF] <= sf;
         rsp_cc[CC_OF] <= of;
      end
   end
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed vectors and multi-cycle sequences for alu_arbiter (flag checks with ALU_CC_EN)
module tb_alu_arbiter;
   import alu_pkg::*;

   typedef struct {
      logic        who;
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic [2:0]  cc;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req0_valid = 1'b0, req1_valid = 1'b0;
   logic        req0_ready, req1_ready;
   logic [1:0]  req0_op = '0, req1_op = '0;
   logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic        rsp0_valid, rsp1_valid;
   logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
   logic [31:0] rsp_result;
`ifdef ALU_CC_EN
   logic [2:0]  rsp_cc;
`endif
   int          n_chk = 0;
   int          n_fail = 0;
   vec_t        tv[9];

   alu_arbiter #(.W(32), .OPW(2)) dut (
      .clk(clk),
      .rst(rst),
      .req0_valid(req0_valid),
      .req0_ready(req0_ready),
      .req0_op(req0_op),
      .req0_a(req0_a),
      .req0_b(req0_b),
      .req1_valid(req1_valid),
      .req1_ready(req1_ready),
      .req1_op(req1_op),
      .req1_a(req1_a),
      .req1_b(req1_b),
      .rsp0_valid(rsp0_valid),
      .rsp0_ready(rsp0_ready),
      .rsp1_valid(rsp1_valid),
      .rsp1_ready(rsp1_ready),
      .rsp_result(rsp_result)
`ifdef ALU_CC_EN
      ,
      .rsp_cc(rsp_cc)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk_cc(input string nm, input logic [2:0] exp);
`ifdef ALU_CC_EN
      chk(nm, {29'd0, rsp_cc}, {29'd0, exp});
`endif
   endtask

   // One complete transaction from requester `who`, checking every phase
   task automatic do_op(input string nm, input logic who, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input logic [2:0] cc);
      @(negedge clk);
      if (who) begin
         req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
      end else begin
         req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
      end
      #1;
      chk({nm, " ready"}, {30'd0, req1_ready, req0_ready}, who ? 32'd2 : 32'd1);
      @(negedge clk);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      #1;
      chk({nm, " exec rsp"}, {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
      @(negedge clk);
      #1;
      chk({nm, " rsp valid"}, {30'd0, rsp1_valid, rsp0_valid}, who ? 32'd2 : 32'd1);
      chk({nm, " result"}, rsp_result, res);
      chk_cc({nm, " cc"}, cc);
      if (who) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
      @(negedge clk);
      rsp0_ready = 1'b0;
      rsp1_ready = 1'b0;
      #1;
      chk({nm, " rsp done"}, {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int g0, g1, nr;
      logic exp_own;
      logic [31:0] exp_res;
      tv[0] = '{1'b0, ALU_ADD, 32'd11,        32'd4,          32'd15,         3'b000};
      tv[1] = '{1'b1, ALU_SUB, 32'd3,         32'd10,         32'd7,          3'b000};
      tv[2] = '{1'b0, ALU_AND, 32'h0000F0F0,  32'h0000FF00,   32'h0000F000,   3'b000};
      tv[3] = '{1'b1, ALU_XOR, 32'd9,         32'd9,          32'd0,          3'b100};
      tv[4] = '{1'b0, ALU_SUB, 32'd2,         32'hFFFFFFF3,   32'hFFFFFFF1,   3'b010};
      tv[5] = '{1'b1, ALU_ADD, 32'h7FFFFFFF,  32'd1,          32'h80000000,   3'b011};
      tv[6] = '{1'b0, ALU_SUB, 32'd1,         32'h80000000,   32'h7FFFFFFF,   3'b001};
      tv[7] = '{1'b0, ALU_ADD, 32'hFFFFFFFF,  32'd1,          32'd0,          3'b100};
      tv[8] = '{1'b1, ALU_AND, 32'h80000000,  32'hFFFFFFFF,   32'h80000000,   3'b010};

      // Reset state: no ready even with a valid request present
      req0_valid = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      chk("reset req0_ready", {31'd0, req0_ready}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      req0_valid = 1'b0;
      #1;
      chk("reset rsp valids", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
      chk("reset result", rsp_result, 32'd0);
      chk_cc("reset cc", 3'b000);

      for (int i = 0; i < 9; i++)
         do_op($sformatf("vec%0d", i), tv[i].who, tv[i].op, tv[i].a, tv[i].b, tv[i].res, tv[i].cc);

      // Fairness: pointer reset to 0, both requesters always valid
      do_reset();
      req0_op = ALU_ADD; req0_b = 32'd1000;
      req1_op = ALU_SUB; req1_b = 32'd500;
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      g0 = 0; g1 = 0; nr = 0; exp_own = 1'b0; exp_res = '0;
      for (int c = 0; c < 80 && nr < 8; c++) begin
         @(negedge clk);
         req0_valid = g0 < 4;
         req1_valid = g1 < 4;
         req0_a = g0;
         req1_a = g1;
         #1;
         if (req0_ready || req1_ready) begin
            chk("rr order", {30'd0, req1_ready, req0_ready}, ((g0 + g1) % 2) ? 32'd2 : 32'd1);
            if (req1_ready) begin
               exp_own = 1'b1; exp_res = 500 - g1; g1++;
            end else begin
               exp_own = 1'b0; exp_res = 1000 + g0; g0++;
            end
         end
         if (rsp0_valid || rsp1_valid) begin
            chk("rr route", {30'd0, rsp1_valid, rsp0_valid}, exp_own ? 32'd2 : 32'd1);
            chk("rr result", rsp_result, exp_res);
            nr++;
         end
      end
      chk("rr responses", nr, 32'd8);
      @(negedge clk);
      req0_valid = 1'b0; req1_valid = 1'b0;
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;

      // Backpressure: rsp0 held off while req1 waits; stray rsp1_ready ignored
      @(negedge clk);
      req0_valid = 1'b1; req0_op = ALU_ADD; req0_a = 32'd20; req0_b = 32'd22;
      #1;
      chk("bp grant0", {31'd0, req0_ready}, 32'd1);
      @(negedge clk);
      req0_valid = 1'b0;
      req1_valid = 1'b1; req1_op = ALU_XOR; req1_a = 32'd5; req1_b = 32'd3;
      rsp1_ready = 1'b1;
      #1;
      chk("bp exec req1_ready", {31'd0, req1_ready}, 32'd0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         #1;
         chk("bp hold valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd1);
         chk("bp hold result", rsp_result, 32'd42);
         chk("bp hold req1_ready", {31'd0, req1_ready}, 32'd0);
      end
      rsp0_ready = 1'b1;
      @(negedge clk);
      rsp0_ready = 1'b0;
      #1;
      chk("bp released", {31'd0, rsp0_valid}, 32'd0);
      chk("bp grant1", {31'd0, req1_ready}, 32'd1);
      @(negedge clk);
      req1_valid = 1'b0;
      #1;
      chk("bp exec1", {31'd0, rsp1_valid}, 32'd0);
      @(negedge clk);
      #1;
      chk("bp rsp1", {30'd0, rsp1_valid, rsp0_valid}, 32'd2);
      chk("bp result1", rsp_result, 32'd6);
      @(negedge clk);
      rsp1_ready = 1'b0;
      #1;
      chk("bp done1", {31'd0, rsp1_valid}, 32'd0);

      // Reset while an op is in EXEC: dropped, never answered
      @(negedge clk);
      req0_valid = 1'b1; req0_op = ALU_ADD; req0_a = 32'd1; req0_b = 32'd2;
      #1;
      chk("mid grant", {31'd0, req0_ready}, 32'd1);
      @(negedge clk);
      req0_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("mid rst handshake", {28'd0, rsp1_valid, rsp0_valid, req1_ready, req0_ready}, 32'd0);
      chk("mid rst result", rsp_result, 32'd0);
      chk_cc("mid rst cc", 3'b000);
      rsp0_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         #1;
         chk("mid dropped", {31'd0, rsp0_valid}, 32'd0);
      end
      rsp0_ready = 1'b0;
      do_op("post rst", 1'b1, ALU_AND, 32'h000000FF, 32'h000000F0, 32'h000000F0, 3'b000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
